if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
Instruction buffer between the fetch stage and the decode stage. It captures each fetched bundle: pc, pcPlus4, instr and the EXT flag. It presents the oldest bundle to decode with valid/stall handshaking. It absorbs decode back-pressure up to DEPTH entries, drives if_ready so fetch holds its PC when full, and discards all buffered work on a branch/jump/interrupt flush.

Parameters:
DEPTH, 2, number of buffered bundles; power of two, >= 2
NOP_INSTR, 32'h00000013, instruction presented on id_instr when empty (addi x0,x0,0)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
if_valid  in  1  fetch presents a bundle this cycle
if_pc  in  32  PC of fetched instruction
if_pcPlus4  in  32  PC+4 of fetched instruction
if_instr  in  32  fetched instruction word
if_ext  in  1  EXT flag from fetch
if_ready  out  1  buffer can accept a bundle (not full)
flush  in  1  discard all buffered and incoming bundles
id_stall  in  1  decode cannot consume this cycle
id_valid  out  1  head bundle is valid
id_pc  out  32  head PC
id_pcPlus4  out  32  head PC+4
id_instr  out  32  head instruction
id_ext  out  1  head EXT flag
count  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Single clock domain: clk. rst is asynchronous and active-high.
- While rst is high: wr_ptr=0, rd_ptr=0, count=0. Hence id_valid=0, if_ready=1, id_instr=NOP_INSTR, id_pc=0, id_pcPlus4=0, id_ext=0. Storage contents are not reset.
- push = if_valid & if_ready & ~flush.
- pop = id_valid & ~id_stall & ~flush.
- if_ready = (count != DEPTH). It depends only on registered state, never on id_stall or if_valid in the same cycle.
- id_valid = (count != 0).
- Head fields are read combinationally from the storage slot at rd_ptr.
- When id_valid=0, the head fields are forced to NOP_INSTR / 0 / 0 / 0.
- Latency: a bundle pushed in cycle N appears on the outputs in cycle N+1 at the earliest. There is no combinational bypass from if_* to id_*.
- On push: write the slot at wr_ptr, then wr_ptr <= wr_ptr+1 mod DEPTH.
- On pop: rd_ptr <= rd_ptr+1 mod DEPTH.
- count update: push & ~pop gives count+1; pop & ~push gives count-1; push & pop leaves count unchanged.
- Simultaneous push and pop is legal whenever 0 < count < DEPTH.
- When full: push is blocked even if a pop occurs in the same cycle. if_ready rises in the cycle after the pop.
- When empty: a pop cannot occur. A push makes id_valid=1 on the next cycle.
- Pointers wrap modulo DEPTH with no error condition. Order is strictly FIFO.
- flush has priority over everything:
  - Next state is wr_ptr=rd_ptr=0, count=0.
  - A concurrent if_valid bundle is dropped.
  - Decode must ignore id_valid in a cycle where flush is asserted.
- Upstream contract: when if_ready=0, fetch holds pc_next=pc so that the same bundle is re-presented.
- Reset asserted mid-operation clears state immediately (asynchronously). All buffered bundles are lost. The first post-reset bundle goes to slot 0.
- count never exceeds DEPTH and never underflows. Add assertions for both.

Test Plan:
- Reset then push pc=0x0, instr=0x00500093 with id_stall=0 -> next cycle id_valid=1, id_pc=0x0, id_pcPlus4=0x4, id_instr=0x00500093; following cycle count=0, id_instr=0x00000013.
- Streaming: push pc 0x0,0x4,0x8,0xC on consecutive cycles, id_stall=0 -> id_pc sequence 0x0,0x4,0x8,0xC one cycle delayed; count stays at 1 once streaming; if_ready always 1.
- Back-pressure: id_stall=1, push 0x10, 0x14 -> count=2 and if_ready=0; a third bundle 0x18 is held and not written. Release id_stall -> outputs 0x10, 0x14, then 0x18 in order; no loss, no duplicate.
- Wrap-around: 10 push/pop cycles with DEPTH=2 and alternating stalls -> order preserved across pointer wrap; count stays within 0..2.
- Flush with count=2 and if_valid=1 (pc 0x40) -> next cycle count=0, id_valid=0, id_instr=0x00000013. Bundle 0x40 is never output. The next push (pc 0x100) is output next.
- Async reset pulse mid-cycle with count=2 -> id_valid=0 and if_ready=1 before the next clk edge. EXT flag pushed as 1 afterwards appears on id_ext=1.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode bundle interface for the IF/ID instruction queue.
// The fetch side presents bundles; the decode side consumes the head bundle.
interface if_id_queue_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_pcPlus4;
    logic [31:0]   if_instr;
    logic          if_ext;
    logic          if_ready;
    logic          flush;
    logic          id_stall;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic [31:0]   id_pcPlus4;
    logic [31:0]   id_instr;
    logic          id_ext;
    logic [CW-1:0] count;

    // Queue side.
    modport slave (
        input  if_valid, if_pc, if_pcPlus4, if_instr, if_ext, flush, id_stall,
        output if_ready, id_valid, id_pc, id_pcPlus4, id_instr, id_ext, count
    );

    // Pipeline (fetch + decode) side.
    modport master (
        output if_valid, if_pc, if_pcPlus4, if_instr, if_ext, flush, id_stall,
        input  if_ready, id_valid, id_pc, id_pcPlus4, id_instr, id_ext, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of fetch bundles with flush, presenting a NOP
// bundle to decode whenever it is empty.
module if_id_queue #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    if_id_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_pc_mem     [DEPTH];
    logic [31:0]   r_pcp4_mem   [DEPTH];
    logic [31:0]   r_instr_mem  [DEPTH];
    logic          r_ext_mem    [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready comes only from registered occupancy, so a pop never frees a slot in the same cycle.
    assign w_push  = bus.if_valid & ~w_full & ~bus.flush;
    assign w_pop   = ~w_empty & ~bus.id_stall & ~bus.flush;

    assign bus.if_ready = ~w_full;
    assign bus.id_valid = ~w_empty;
    assign bus.count    = r_count;

    assign bus.id_pc      = w_empty ? 32'h0     : r_pc_mem[r_rd_ptr];
    assign bus.id_pcPlus4 = w_empty ? 32'h0     : r_pcp4_mem[r_rd_ptr];
    assign bus.id_instr   = w_empty ? NOP_INSTR : r_instr_mem[r_rd_ptr];
    assign bus.id_ext     = w_empty ? 1'b0      : r_ext_mem[r_rd_ptr];

    // Storage is deliberately not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= bus.if_pc;
            r_pcp4_mem[r_wr_ptr]  <= bus.if_pcPlus4;
            r_instr_mem[r_wr_ptr] <= bus.if_instr;
            r_ext_mem[r_wr_ptr]   <= bus.if_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk) disable iff (rst) r_count <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) w_empty |-> !w_pop);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) w_full |-> !w_push);
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_if_id_queue;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst;

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] instr;
        logic        ext;
    } bundle_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ext;
        logic        fl;
        logic        st;
        logic        ev;
        logic        er;
        int          ecnt;
        logic [31:0] epc;
        logic        eext;
    } vec_t;

    bundle_t mq[$];
    vec_t    vecs[20];
    int      n_checks = 0;
    int      n_fail   = 0;

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hA000_0093 | pc;
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic ext,
                                input logic fl, input logic st, input logic ev, input logic er,
                                input int ecnt, input logic [31:0] epc, input logic eext);
        vec_t r;
        r.v = v; r.pc = pc; r.ext = ext; r.fl = fl; r.st = st;
        r.ev = ev; r.er = er; r.ecnt = ecnt; r.epc = epc; r.eext = eext;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] p4,
                         input logic [31:0] instr, input logic ext, input logic fl,
                         input logic st);
        bus.if_valid   = v;
        bus.if_pc      = pc;
        bus.if_pcPlus4 = p4;
        bus.if_instr   = instr;
        bus.if_ext     = ext;
        bus.flush      = fl;
        bus.id_stall   = st;
    endtask

    // Reference: applies one clock of the queue rules to the model using current inputs.
    task automatic model_update();
        bit      ready;
        bit      valid;
        bundle_t b;
        ready = (mq.size() != DEPTH);
        valid = (mq.size() != 0);
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (valid && !bus.id_stall) void'(mq.pop_front());
            if (bus.if_valid && ready) begin
                b.pc = bus.if_pc; b.pcp4 = bus.if_pcPlus4;
                b.instr = bus.if_instr; b.ext = bus.if_ext;
                mq.push_back(b);
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit nonempty;
        nonempty = (mq.size() != 0);
        chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'(nonempty));
        chk({tag, ".if_ready"}, 32'(bus.if_ready), 32'(mq.size() != DEPTH));
        chk({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        chk({tag, ".id_pc"}, bus.id_pc, nonempty ? mq[0].pc : 32'h0);
        chk({tag, ".id_pcPlus4"}, bus.id_pcPlus4, nonempty ? mq[0].pcp4 : 32'h0);
        chk({tag, ".id_instr"}, bus.id_instr, nonempty ? mq[0].instr : NOP);
        chk({tag, ".id_ext"}, 32'(bus.id_ext), 32'(nonempty ? mq[0].ext : 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.id_valid", 32'(bus.id_valid), 32'd0);
        chk("reset.if_ready", 32'(bus.if_ready), 32'd1);
        chk("reset.count", 32'(bus.count), 32'd0);
        chk("reset.id_instr", bus.id_instr, NOP);
        chk("reset.id_pc", bus.id_pc, 32'h0);
        chk("reset.id_pcPlus4", bus.id_pcPlus4, 32'h0);
        chk("reset.id_ext", 32'(bus.id_ext), 32'd0);
        rst = 1'b0;

        //            v  pc        ext fl st  ev er cnt epc        eext
        vecs[0]  = mk(1, 32'h0,    0,  0, 0,  1, 1, 1,  32'h0,    0);
        vecs[1]  = mk(0, 32'h0,    0,  0, 0,  0, 1, 0,  32'h0,    0);
        vecs[2]  = mk(1, 32'h0,    0,  0, 0,  1, 1, 1,  32'h0,    0);
        vecs[3]  = mk(1, 32'h4,    0,  0, 0,  1, 1, 1,  32'h4,    0);
        vecs[4]  = mk(1, 32'h8,    0,  0, 0,  1, 1, 1,  32'h8,    0);
        vecs[5]  = mk(1, 32'hC,    0,  0, 0,  1, 1, 1,  32'hC,    0);
        vecs[6]  = mk(0, 32'h0,    0,  0, 0,  0, 1, 0,  32'h0,    0);
        vecs[7]  = mk(1, 32'h10,   0,  0, 1,  1, 1, 1,  32'h10,   0);
        vecs[8]  = mk(1, 32'h14,   0,  0, 1,  1, 0, 2,  32'h10,   0);
        vecs[9]  = mk(1, 32'h18,   0,  0, 1,  1, 0, 2,  32'h10,   0);
        vecs[10] = mk(1, 32'h18,   0,  0, 0,  1, 1, 1,  32'h14,   0);
        vecs[11] = mk(1, 32'h18,   0,  0, 0,  1, 1, 1,  32'h18,   0);
        vecs[12] = mk(0, 32'h0,    0,  0, 0,  0, 1, 0,  32'h0,    0);
        vecs[13] = mk(1, 32'h20,   1,  0, 1,  1, 1, 1,  32'h20,   1);
        vecs[14] = mk(1, 32'h24,   0,  0, 1,  1, 0, 2,  32'h20,   1);
        vecs[15] = mk(1, 32'h40,   0,  1, 1,  0, 1, 0,  32'h0,    0);
        vecs[16] = mk(1, 32'h100,  0,  0, 1,  1, 1, 1,  32'h100,  0);
        vecs[17] = mk(0, 32'h0,    0,  0, 0,  0, 1, 0,  32'h0,    0);
        vecs[18] = mk(1, 32'h200,  1,  0, 1,  1, 1, 1,  32'h200,  1);
        vecs[19] = mk(0, 32'h0,    0,  0, 0,  0, 1, 0,  32'h0,    0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] instr;
            instr = (i == 0) ? 32'h0050_0093 : ins_of(vecs[i].pc);
            drive(vecs[i].v, vecs[i].pc, vecs[i].pc + 32'd4, instr, vecs[i].ext, vecs[i].fl,
                  vecs[i].st);
            step();
            chk($sformatf("vec%0d.id_valid", i), 32'(bus.id_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d.if_ready", i), 32'(bus.if_ready), 32'(vecs[i].er));
            chk($sformatf("vec%0d.count", i), 32'(bus.count), 32'(vecs[i].ecnt));
            chk($sformatf("vec%0d.id_pc", i), bus.id_pc, vecs[i].epc);
            chk($sformatf("vec%0d.id_pcPlus4", i), bus.id_pcPlus4,
                vecs[i].ev ? vecs[i].epc + 32'd4 : 32'h0);
            chk($sformatf("vec%0d.id_instr", i), bus.id_instr,
                !vecs[i].ev ? NOP : (i == 0) ? 32'h0050_0093 : ins_of(vecs[i].epc));
            chk($sformatf("vec%0d.id_ext", i), 32'(bus.id_ext), 32'(vecs[i].eext));
        end

        // Wrap-around with alternating stalls.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h400 + 32'(k * 4), 32'h404 + 32'(k * 4), ins_of(32'h400 + 32'(k * 4)),
                  k[0], 1'b0, k[0]);
            step();
            check_model($sformatf("wrap%0d", k));
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            step();
            check_model($sformatf("drain%0d", k));
        end

        // Asynchronous reset pulse in the middle of a cycle with the queue full.
        drive(1'b1, 32'h500, 32'h504, ins_of(32'h500), 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h504, 32'h508, ins_of(32'h504), 1'b0, 1'b0, 1'b1);
        step();
        check_model("prerst");
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.id_valid", 32'(bus.id_valid), 32'd0);
        chk("arst.if_ready", 32'(bus.if_ready), 32'd1);
        chk("arst.count", 32'(bus.count), 32'd0);
        chk("arst.id_instr", bus.id_instr, NOP);
        mq.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h300, 32'h304, ins_of(32'h300), 1'b1, 1'b0, 1'b1);
        step();
        chk("postrst.id_ext", 32'(bus.id_ext), 32'd1);
        chk("postrst.id_pc", bus.id_pc, 32'h300);
        check_model("postrst");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(99) < 70), $urandom, $urandom, $urandom, 1'($urandom),
                  1'($urandom_range(99) < 6), 1'($urandom_range(99) < 40));
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
